// File: rtl/stack_pkg.sv
// Shared encodings and default geometry for the stack pointer sequencer.
package stack_pkg;

    localparam int unsigned DATA_W = 16;
    localparam logic [15:0] DEF_STACK_BASE  = 16'h0200;
    localparam logic [15:0] DEF_STACK_LIMIT = 16'h0100;

    // Command opcodes from the control unit
    typedef enum logic [1:0] {
        OP_INIT = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD       = 3'd1,
        ST_PUSH_DEC = 3'd2,
        ST_PUSH_WR  = 3'd3,
        ST_POP_RD   = 3'd4,
        ST_POP_INC  = 3'd5,
        ST_RESP     = 3'd6
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack operation sequencer: drives SP strobes and the data-memory port for
// INIT/LOAD/PUSH/POP, checks stack bounds, returns one response pulse.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned  W           = DATA_W,
    parameter logic [W-1:0] STACK_BASE  = W'(DEF_STACK_BASE),
    parameter logic [W-1:0] STACK_LIMIT = W'(DEF_STACK_LIMIT)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         cmd_ready,
    input  logic [W-1:0] sp_val,
    output logic         sp_ld,
    output logic         sp_inc,
    output logic         sp_dec,
    output logic [W-1:0] sp_din,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err
);

    state_e       state;
    logic [W-1:0] data_q;
    logic [W-1:0] rdata_q;

    // SP settles the cycle after a strobe and is stable during memory access,
    // so the address follows it directly whenever a request is up.
    assign mem_addr = mem_req ? sp_val : '0;

    // Sequencer with registered strobes, memory handshake and response
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            rdata_q   <= '0;
            cmd_ready <= 1'b1;
            sp_ld     <= 1'b0;
            sp_inc    <= 1'b0;
            sp_dec    <= 1'b0;
            sp_din    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            sp_ld     <= 1'b0;
            sp_inc    <= 1'b0;
            sp_dec    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        data_q    <= cmd_data;
                        case (op_e'(cmd_op))
                            OP_INIT: begin
                                state  <= ST_LD;
                                sp_ld  <= 1'b1;
                                sp_din <= STACK_BASE;
                            end
                            OP_LOAD: begin
                                state  <= ST_LD;
                                sp_ld  <= 1'b1;
                                sp_din <= cmd_data;
                            end
                            OP_PUSH: begin
                                if (sp_val == STACK_LIMIT) begin
                                    state     <= ST_RESP;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                end else begin
                                    state  <= ST_PUSH_DEC;
                                    sp_dec <= 1'b1;
                                end
                            end
                            default: begin
                                if (sp_val == STACK_BASE) begin
                                    state     <= ST_RESP;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                end else begin
                                    state   <= ST_POP_RD;
                                    mem_req <= 1'b1;
                                    mem_we  <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                ST_LD: begin
                    sp_din    <= '0;
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                end
                ST_PUSH_DEC: begin
                    state     <= ST_PUSH_WR;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= data_q;
                end
                ST_PUSH_WR: begin
                    if (mem_ack) begin
                        state     <= ST_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_POP_RD: begin
                    if (mem_ack) begin
                        state   <= ST_POP_INC;
                        mem_req <= 1'b0;
                        rdata_q <= mem_rdata;
                        sp_inc  <= 1'b1;
                    end
                end
                ST_POP_INC: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rdata_q;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    data_q    <= '0;
                    rdata_q   <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Closed-loop bench for stack_ctrl: SP register and memory models around the
// DUT, a stack-level reference model and a response scoreboard.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam logic [15:0] BASE  = 16'h0200;
    localparam logic [15:0] LIMIT = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_data = 16'h0;
    logic        cmd_ready;
    logic [15:0] sp = 16'h0;
    logic        sp_ld, sp_inc, sp_dec;
    logic [15:0] sp_din;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;

    stack_ctrl dut (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .sp_val(sp), .sp_ld(sp_ld), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_din(sp_din),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] data;
        logic [15:0] sp;
        logic [15:0] ldv;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ewq[$];
    int          dq[$];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] mem     [logic [15:0]];
    logic [15:0] ref_sp = 16'h0;
    int n_chk = 0, n_fail = 0, cyc = 0, acc_count = 0, next_delay = 0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SP register as the real one behaves: own reset to 0, one strobe per edge
    always @(posedge clk) begin
        if (!rst_b)      sp <= 16'h0;
        else if (sp_ld)  sp <= sp_din;
        else if (sp_inc) sp <= sp + 16'h1;
        else if (sp_dec) sp <= sp - 16'h1;
    end

    // Memory model with per-transaction ack delay and stability checks
    bit          m_busy = 1'b0;
    int          m_cnt = 0, m_dly = 0;
    logic [15:0] m_addr, m_wd;
    logic        m_we;
    always @(posedge clk) begin
        #2;
        if (!mem_req) begin
            mem_ack = 1'b0;
            m_busy  = 1'b0;
            m_cnt   = 0;
        end else begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_addr = mem_addr;
                m_we   = mem_we;
                m_wd   = mem_wdata;
                if (dq.size() != 0) m_dly = dq.pop_front();
                else begin m_dly = 0; fail_now("mem_req_unexpected"); end
            end else begin
                chk("mem_addr_stable", 32'(mem_addr), 32'(m_addr));
                chk("mem_we_stable", 32'(mem_we), 32'(m_we));
                chk("mem_wdata_stable", 32'(mem_wdata), 32'(m_wd));
            end
            if (m_cnt == m_dly) begin
                mem_ack = 1'b1;
                m_busy  = 1'b0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    if (ewq.size() == 0) fail_now("mem_write_unexpected");
                    else chk("mem_write", {mem_addr, mem_wdata}, ewq.pop_front());
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                m_cnt++;
            end
        end
    end

    // Monitor: invariants, response scoreboard, and reference model on accept
    exp_t me;
    int   md;
    always @(negedge clk) begin
        if (rst_b) begin
            chk("strobe_excl", 32'(($countones({sp_ld, sp_inc, sp_dec}) <= 1) &&
                                  !((sp_ld | sp_inc | sp_dec) && mem_req)), 32'd1);
            if (sb.size() != 0 && sb[0].err)
                chk("err_quiet", 32'({sp_ld, sp_inc, sp_dec, mem_req}), 32'd0);
            if (sp_ld) begin
                if (sb.size() == 0) fail_now("sp_ld_unexpected");
                else chk("sp_din", 32'(sp_din), 32'(sb[0].ldv));
            end
            if (rsp_valid) begin
                if (sb.size() == 0) fail_now("rsp_unexpected");
                else begin
                    me = sb.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(me.err));
                    chk("rsp_data", 32'(rsp_data), 32'(me.data));
                    chk("rsp_latency", 32'(cyc - me.acc + 1), 32'(me.lat));
                    chk("sp_after", 32'(sp), 32'(me.sp));
                end
            end
            if (cmd_valid && cmd_ready) begin
                chk("no_overlap", 32'(sb.size()), 32'd0);
                me.err = 1'b0; me.data = 16'h0; me.ldv = 16'h0;
                me.acc = cyc + 1;
                md = next_delay;
                case (cmd_op)
                    2'b00: begin ref_sp = BASE; me.ldv = BASE; me.lat = 2; end
                    2'b11: begin ref_sp = cmd_data; me.ldv = cmd_data; me.lat = 2; end
                    2'b01: begin
                        if (ref_sp == LIMIT) begin me.err = 1'b1; me.lat = 1; end
                        else begin
                            ref_sp = ref_sp - 16'h1;
                            ref_mem[ref_sp] = cmd_data;
                            ewq.push_back({ref_sp, cmd_data});
                            dq.push_back(md);
                            me.lat = 3 + md;
                        end
                    end
                    default: begin
                        if (ref_sp == BASE) begin me.err = 1'b1; me.lat = 1; end
                        else begin
                            me.data = ref_mem.exists(ref_sp) ? ref_mem[ref_sp] : init_val(ref_sp);
                            ref_sp = ref_sp + 16'h1;
                            dq.push_back(md);
                            me.lat = 3 + md;
                        end
                    end
                endcase
                me.sp = ref_sp;
                sb.push_back(me);
                acc_count++;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] d, input int dly, input bit hold);
        int n0;
        bit ok;
        n0 = acc_count;
        ok = 1'b0;
        next_delay = dly;
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (acc_count != n0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("accept_timeout");
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) fail_now("response_timeout");
    endtask

    task automatic do_reset(input int n);
        rst_b = 1'b0;
        cmd_valid = 1'b0;
        sb.delete();
        ewq.delete();
        dq.delete();
        ref_sp = 16'h0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_flags", 32'({cmd_ready, sp_ld, sp_inc, sp_dec, mem_req, mem_we, rsp_valid, rsp_err}),
            32'h80);
        chk("rst_buses", {sp_din, mem_addr}, 32'd0);
        chk("rst_data", {mem_wdata, rsp_data}, 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        rst_b = 1'b1;
    endtask

    initial begin
        bit ok;
        int r;
        logic [1:0]  op;
        logic [15:0] d;

        @(posedge clk); #1;
        do_reset(3);

        issue(OP_INIT, 16'h0, 0, 1'b0);            wait_idle();
        issue(OP_PUSH, 16'hABCD, 0, 1'b0);         wait_idle();
        issue(OP_PUSH, 16'h1234, 0, 1'b0);         wait_idle();
        issue(OP_POP, 16'h0, 0, 1'b0);             wait_idle();
        issue(OP_POP, 16'h0, 2, 1'b0);             wait_idle();
        issue(OP_POP, 16'h0, 0, 1'b0);             wait_idle();
        issue(OP_LOAD, LIMIT, 0, 1'b0);            wait_idle();
        issue(OP_PUSH, 16'h5555, 0, 1'b0);         wait_idle();
        issue(OP_POP, 16'h0, 1, 1'b0);             wait_idle();

        issue(OP_INIT, 16'h0, 0, 1'b0);            wait_idle();
        issue(OP_PUSH, 16'hBEEF, 3, 1'b1);
        issue(OP_PUSH, 16'hCAFE, 0, 1'b1);
        issue(OP_POP, 16'h0, 1, 1'b0);             wait_idle();

        // Reset while a POP read is waiting for its ack
        issue(OP_POP, 16'h0, 6, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) fail_now("midop_req_timeout");
        @(posedge clk); #1;
        rst_b = 1'b0;
        cmd_valid = 1'b0;
        sb.delete();
        ewq.delete();
        dq.delete();
        ref_sp = 16'h0;
        @(posedge clk); #1;
        chk("midop_state", 32'({mem_req, cmd_ready, rsp_valid}), 32'b010);
        chk("midop_sp", 32'(sp), 32'd0);
        rst_b = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        issue(OP_INIT, 16'h0, 0, 1'b0);            wait_idle();
        for (int k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 99));
            d = 16'($urandom);
            if (r < 42)      op = OP_PUSH;
            else if (r < 84) op = OP_POP;
            else if (r < 88) op = OP_INIT;
            else begin
                op = OP_LOAD;
                d  = 16'($urandom_range(32'h0100, 32'h0200));
            end
            issue(op, d, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
            if (!cmd_valid) wait_idle();
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        chk("leftover_writes", 32'(ewq.size()), 32'd0);
        chk("leftover_reqs", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencer for the 16-bit stack pointer register (SP: ld/inc/dec/in/out) and the data-memory port during stack operations. Accepts one INIT/LOAD/PUSH/POP command at a time from the control unit and drives SP strobes and memory handshakes in order. Checks stack bounds and returns a single response pulse with pop data or an error. Sits between the control unit, the SP instance and the memory interface.

Parameters:
W, 16, data/address width
STACK_BASE, 16'h0200, empty-stack SP value; INIT loads it; POP refused when SP == STACK_BASE
STACK_LIMIT, 16'h0100, full-stack SP value; PUSH refused when SP == STACK_LIMIT

Ports:
clk  in  1  clock, all state on rising edge
rst_b  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_op  in  2  00 INIT, 01 PUSH, 10 POP, 11 LOAD
cmd_data  in  W  PUSH data or LOAD value
cmd_ready  out  1  high only in IDLE
sp_val  in  W  SP out
sp_ld / sp_inc / sp_dec  out  1 each  SP strobes
sp_din  out  W  SP in
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 write, 0 read
mem_addr  out  W  address
mem_wdata  out  W  write data
mem_rdata  in  W  read data, valid with mem_ack
mem_ack  in  1  memory completion, may come in the first req cycle
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  W  POP data (0 otherwise)
rsp_err  out  1  bound violation, valid with rsp_valid

Behaviour:
- Reset (rst_b=0 at edge): state IDLE; every output 0 except cmd_ready=1; latched op/data cleared. Mid-operation reset aborts: mem_req drops next cycle, no rsp_valid. SP is not touched; SP resets itself to 0, so software issues INIT.
- Descending stack, pre-decrement PUSH, post-increment POP. SP updates one edge after its strobe, so sp_val is sampled only in the cycle after any strobe.
- States: IDLE, LD, PUSH_DEC, PUSH_WR, POP_RD, POP_INC, RESP.
- IDLE: cmd_valid & cmd_ready latches op/data. INIT -> LD with sp_din=STACK_BASE. LOAD -> LD with sp_din=cmd_data, no bound check. PUSH: sp_val==STACK_LIMIT -> RESP with err, else PUSH_DEC. POP: sp_val==STACK_BASE -> RESP with err, else POP_RD.
- LD: sp_ld=1 for 1 cycle -> RESP.
- PUSH_DEC: sp_dec=1 for 1 cycle -> PUSH_WR.
- PUSH_WR: mem_req=1, mem_we=1, mem_addr=sp_val, mem_wdata=latched data, held stable; on mem_ack -> RESP.
- POP_RD: mem_req=1, mem_we=0, mem_addr=sp_val; on mem_ack latch mem_rdata -> POP_INC.
- POP_INC: sp_inc=1 for 1 cycle -> RESP.
- RESP: rsp_valid=1 with rsp_data and rsp_err for exactly 1 cycle -> IDLE. Next command is accepted the cycle after RESP.
- Latency with same-cycle ack: accept edge + 3 cycles to rsp_valid for PUSH/POP, +2 for INIT/LOAD. Each mem_ack wait cycle adds 1.
- Invariants: at most one of sp_ld/sp_inc/sp_dec high per cycle. Strobes are never high while mem_req=1. Erroring commands issue no strobe and no mem_req. cmd_valid is ignored when cmd_ready=0. mem_ack outside a req state is ignored.
- Arithmetic is done by SP. Bound compares are exact-equality; LOAD outside [STACK_LIMIT, STACK_BASE] is the caller's responsibility.

Decomposition:
- stack_pkg: cmd_op encodings (OP_INIT, OP_PUSH, OP_POP, OP_LOAD) and state encoding constants.
- No sub-module inside stack_ctrl.
- Verification wrapper stack_unit instantiates SP + stack_ctrl (sp_val=SP.out) for closed-loop benches.

Test Plan:
- Reset, then INIT -> sp_ld pulse with sp_din=0x0200; rsp_valid, err=0; SP=0x0200.
- PUSH 0xABCD, PUSH 0x1234 (ack same cycle) -> writes 0x01FF=ABCD, 0x01FE=1234; SP=0x01FE; each rsp 3 cycles after accept.
- POP, POP with ack delayed 2 cycles -> rsp_data 0x1234 then 0xABCD; SP=0x0200; mem_addr/mem_we stable while waiting.
- POP at SP=0x0200 -> rsp_err=1, no strobe, no mem_req; SP unchanged. LOAD 0x0100, then PUSH -> rsp_err=1.
- cmd_valid held high during a busy PUSH -> second command accepted only after RESP; never two strobes in one cycle (assertion).
- rst_b=0 during POP_RD wait -> mem_req low next cycle, no rsp_valid, cmd_ready=1; SP reads 0 after its own reset.
